wb_stage_pipe: RTL

//  Registered, parametrised writeback stage; replaces the combinational 2-source wb mux.

---
 rtl/wb_stage_pipe.sv | 132 +++++++++++++
 1 files changed

// File: rtl/wb_stage_pipe.sv
// Registered writeback stage: 4-way result select with sub-word load extraction,
// misalignment detection, x0/illegal write suppression and a wrapping retire counter.
module wb_stage_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_in,
  input  logic             reg_file_write_in,
  input  logic [AW-1:0]    addr_rd,
  input  logic [1:0]       select_mux,
  input  logic [XLEN-1:0]  mem_out,
  input  logic [XLEN-1:0]  alu_out,
  input  logic [XLEN-1:0]  pc_plus4,
  input  logic [XLEN-1:0]  imm,
  input  logic [2:0]       load_funct3,
  output logic [XLEN-1:0]  wb_data,
  output logic [AW-1:0]    addr_out,
  output logic             reg_file_write_out,
  output logic             valid_out,
  output logic             misalign_err,
  output logic [CNT_W-1:0] retire_count
);

  typedef enum logic [1:0] {
    SEL_MEM = 2'b00,
    SEL_ALU = 2'b01,
    SEL_PC4 = 2'b10,
    SEL_IMM = 2'b11
  } sel_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } ld_f3_e;

  sel_e             sel;
  logic [1:0]       off;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [XLEN-1:0]  load_val;
  logic             ld_misaligned;
  logic             misaligned;

  logic [XLEN-1:0]  wb_data_q,  wb_data_d;
  logic [AW-1:0]    addr_q;
  logic             we_q,       we_d;
  logic             valid_q;
  logic             mis_q,      mis_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  assign sel = sel_e'(select_mux);
  assign off = alu_out[1:0];

  always_comb begin
    ld_byte       = mem_out[7:0];
    ld_half       = off[1] ? mem_out[31:16] : mem_out[15:0];
    load_val      = mem_out;
    ld_misaligned = 1'b0;
    case (off)
      2'd0:    ld_byte = mem_out[7:0];
      2'd1:    ld_byte = mem_out[15:8];
      2'd2:    ld_byte = mem_out[23:16];
      default: ld_byte = mem_out[31:24];
    endcase
    // Reserved funct3 encodings fall into the word case.
    case (load_funct3)
      F3_LB:   load_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LBU:  load_val = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LH: begin
        load_val      = {{(XLEN-16){ld_half[15]}}, ld_half};
        ld_misaligned = off[0];
      end
      F3_LHU: begin
        load_val      = {{(XLEN-16){1'b0}}, ld_half};
        ld_misaligned = off[0];
      end
      default: ld_misaligned = (off != 2'b00);
    endcase
  end

  always_comb begin
    misaligned = (sel == SEL_MEM) && ld_misaligned;
    wb_data_d  = load_val;
    case (sel)
      SEL_MEM: wb_data_d = load_val;
      SEL_ALU: wb_data_d = alu_out;
      SEL_PC4: wb_data_d = pc_plus4;
      default: wb_data_d = imm;
    endcase
    we_d  = valid_in && reg_file_write_in && (addr_rd != '0) && !misaligned;
    mis_d = valid_in && misaligned;
    cnt_d = cnt_q + CNT_W'(1);
  end

  // Flush only clears the qualifying flags; data and address are don't-care and simply hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data_q <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      valid_q   <= 1'b0;
      mis_q     <= 1'b0;
      cnt_q     <= '0;
    end else if (flush) begin
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else if (!stall) begin
      wb_data_q <= wb_data_d;
      addr_q    <= addr_rd;
      we_q      <= we_d;
      valid_q   <= valid_in;
      mis_q     <= mis_d;
      if (valid_in) cnt_q <= cnt_d;
    end
  end

  assign wb_data            = wb_data_q;
  assign addr_out           = addr_q;
  assign reg_file_write_out = we_q;
  assign valid_out          = valid_q;
  assign misalign_err       = mis_q;
  assign retire_count       = cnt_q;

endmodule
